// File: rtl/io_host_driver_pkg.sv
// Shared definitions for the host-side CPU I/O port driver:
// bus widths, on/off levels, FSM state encoding and a counter sizing helper.
package io_host_driver_pkg;

  localparam int IOH_BIT_INST   = 16;
  localparam int IOH_BIT_DATA   = 8;
  localparam int IOH_FIFO_DEPTH = 4;

  localparam logic OFF = 1'b0;
  localparam logic ON  = 1'b1;

  typedef enum logic [1:0] {
    IOH_IDLE  = 2'd0,
    IOH_ISSUE = 2'd1,
    IOH_WAIT  = 2'd2,
    IOH_RESP  = 2'd3
  } ioh_state_e;

  // Width of a down-counter that must hold values up to max(int_cyc, rd_lat).
  function automatic int ioh_cnt_width(input int int_cyc, input int rd_lat);
    int m;
    m = (int_cyc > rd_lat) ? int_cyc : rd_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/io_host_fifo.sv
// Small synchronous command FIFO with show-ahead read data.
// A push while full is dropped even when a pop happens in the same cycle;
// a simultaneous push and pop on a non-full, non-empty FIFO keeps the count.
// DEPTH must be a power of two so the pointers wrap naturally.
module io_host_fifo
  import io_host_driver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = IOH_FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Storage array: written on an accepted push only.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_host_driver.sv
// Host-side master for the CPU I/O port. Each accepted command is issued as
// an interrupt window carrying io_inst/io_din; read commands then sample
// io_dout after a fixed latency and return it on the response stream.
// One command in flight at a time.
// Build option: IO_HOST_FIFO_EN adds a 4-entry command FIFO ahead of the FSM.
//
// Handshakes: a beat transfers on a rising clock edge where valid and ready
// are both high. The command side may drop or change cmd_* freely while
// cmd_ready is low. rsp_valid stays high and rsp_data stays stable until the
// edge on which rsp_ready is seen; rsp_ready with no rsp_valid has no effect.
module io_host_driver
  import io_host_driver_pkg::*;
#(
  parameter int BIT_INST = IOH_BIT_INST,
  parameter int BIT_DATA = IOH_BIT_DATA,
  parameter int INT_CYC  = 1,
  parameter int RD_LAT   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [BIT_INST-1:0] cmd_inst,
  input  logic [BIT_DATA-1:0] cmd_data,
  input  logic                cmd_rd,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [BIT_DATA-1:0] rsp_data,
  output logic                busy,
  output logic                interrupt,
  output logic [BIT_INST-1:0] io_inst,
  output logic [BIT_DATA-1:0] io_din,
  input  logic [BIT_DATA-1:0] io_dout,
  output logic [1:0]          o_dbg_state
);

  localparam int CNT_W = ioh_cnt_width(INT_CYC, RD_LAT);
  localparam int CMD_W = 1 + BIT_INST + BIT_DATA;

  ioh_state_e          r_state;
  ioh_state_e          w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                r_rd;
  logic                w_rd_next;
  logic                r_interrupt;
  logic                w_interrupt_next;
  logic [BIT_INST-1:0] r_io_inst;
  logic [BIT_INST-1:0] w_io_inst_next;
  logic [BIT_DATA-1:0] r_io_din;
  logic [BIT_DATA-1:0] w_io_din_next;
  logic                r_rsp_valid;
  logic                w_rsp_valid_next;
  logic [BIT_DATA-1:0] r_rsp_data;
  logic [BIT_DATA-1:0] w_rsp_data_next;

  // Command presented to the FSM and the strobe that starts it.
  logic                w_take;
  logic [CMD_W-1:0]    w_head;
  logic                w_head_rd;
  logic [BIT_INST-1:0] w_head_inst;
  logic [BIT_DATA-1:0] w_head_data;

`ifdef IO_HOST_FIFO_EN
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_push;
  logic [CMD_W-1:0] w_fifo_head;

  assign cmd_ready = ~w_fifo_full & ~reset;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_take    = (r_state == IOH_IDLE) & ~w_fifo_empty;
  assign w_head    = w_fifo_head;
  assign busy      = (r_state != IOH_IDLE) | ~w_fifo_empty;

  io_host_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (IOH_FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data ({cmd_rd, cmd_inst, cmd_data}),
    .i_pop       (w_take),
    .o_pop_data  (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );
`else
  assign cmd_ready = (r_state == IOH_IDLE) & ~reset;
  assign w_take    = cmd_valid & cmd_ready;
  assign w_head    = {cmd_rd, cmd_inst, cmd_data};
  assign busy      = (r_state != IOH_IDLE);
`endif

  assign {w_head_rd, w_head_inst, w_head_data} = w_head;

  assign interrupt   = r_interrupt;
  assign io_inst     = r_io_inst;
  assign io_din      = r_io_din;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign o_dbg_state = r_state;

  // Next-state and next registered-output logic; everything holds by default.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_rd_next        = r_rd;
    w_interrupt_next = r_interrupt;
    w_io_inst_next   = r_io_inst;
    w_io_din_next    = r_io_din;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_data_next  = r_rsp_data;
    case (r_state)
      IOH_IDLE: begin
        if (w_take) begin
          w_state_next     = IOH_ISSUE;
          w_cnt_next       = CNT_W'(INT_CYC - 1);
          w_rd_next        = w_head_rd;
          w_interrupt_next = ON;
          w_io_inst_next   = w_head_inst;
          w_io_din_next    = w_head_data;
        end
      end
      IOH_ISSUE: begin
        if (r_cnt == '0) begin
          w_interrupt_next = OFF;
          w_io_inst_next   = '0;
          if (r_rd) begin
            // io_din keeps the operand while the CPU produces io_dout.
            w_state_next = IOH_WAIT;
            w_cnt_next   = CNT_W'(RD_LAT - 1);
          end else begin
            w_state_next  = IOH_IDLE;
            w_io_din_next = '0;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      IOH_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next     = IOH_RESP;
          w_rsp_valid_next = ON;
          w_rsp_data_next  = io_dout;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      IOH_RESP: begin
        // rsp_data deliberately keeps its last value after the handshake.
        if (rsp_ready) begin
          w_state_next     = IOH_IDLE;
          w_rsp_valid_next = OFF;
          w_io_din_next    = '0;
        end
      end
      default: begin
        w_state_next = IOH_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the in-flight command at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IOH_IDLE;
      r_cnt       <= '0;
      r_rd        <= OFF;
      r_interrupt <= OFF;
      r_io_inst   <= '0;
      r_io_din    <= '0;
      r_rsp_valid <= OFF;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_rd        <= w_rd_next;
      r_interrupt <= w_interrupt_next;
      r_io_inst   <= w_io_inst_next;
      r_io_din    <= w_io_din_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
    end
  end

endmodule
